// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port synchronous VRAM between the
// display tile fetcher (highest priority) and a CPU load/store port.
// Display fetches are derived from the VGA timing counters and run one
// 8-pixel group ahead of use. The CPU takes every other memory slot.
//
// CPU handshake: the requester raises cpu_req with cpu_we/cpu_addr/cpu_wdata
// stable and holds it until cpu_ack. cpu_ack is a one-cycle pulse; read data
// is valid on cpu_rdata while cpu_ack is high and held afterwards. cpu_req is
// ignored during the ack cycle, so the requester drops or renews it then;
// back-to-back CPU accesses therefore take at least 4 cycles each.
module vga_vram_arbiter #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int          H_ACTIVE_START = 160,
  parameter int          V_ACTIVE       = 480,
  parameter int          TILES_PER_ROW  = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] tile_word,
  output logic        tile_valid,
  output logic        underrun,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // Horizontal windows: fetches start one group before the active area and
  // stop one group before its end; loads cover the whole active area.
  localparam logic [9:0]  H_TRIG_FIRST = 10'(H_ACTIVE_START - 8);
  localparam logic [9:0]  H_TRIG_END   = 10'(H_ACTIVE_START + TILES_PER_ROW * 8 - 8);
  localparam logic [9:0]  H_ACT_FIRST  = 10'(H_ACTIVE_START);
  localparam logic [9:0]  H_ACT_END    = 10'(H_ACTIVE_START + TILES_PER_ROW * 8);
  localparam logic [9:0]  V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [15:0] ROW_STEP     = 16'(TILES_PER_ROW);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_sel_disp;
  logic        w_sel_cpu;

  logic        r_disp_pend;
  logic [15:0] r_disp_addr;
  logic [15:0] r_row_off;
  logic [15:0] r_col;
  logic        r_is_disp;
  logic [15:0] r_next_word;
  logic        r_next_ok;

  logic        r_cpu_ack;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_mem_addr;
  logic        r_mem_we;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_tile_word;
  logic        r_tile_valid;
  logic        r_underrun;

  logic        w_group_edge;
  logic        w_v_active;
  logic        w_trig;
  logic        w_first_group;
  logic        w_in_active;
  logic        w_load;
  logic        w_disp_req;
  logic        w_capture;
  logic [15:0] w_trig_addr;
  logic [15:0] w_disp_sel_addr;

  assign w_group_edge  = pix_en && (hcount[2:0] == 3'd0);
  assign w_v_active    = vcount < V_ACT_END;
  assign w_trig        = w_group_edge && w_v_active &&
                         (hcount >= H_TRIG_FIRST) && (hcount < H_TRIG_END);
  assign w_first_group = hcount == H_TRIG_FIRST;
  assign w_in_active   = w_v_active && (hcount >= H_ACT_FIRST) && (hcount < H_ACT_END);
  assign w_load        = w_group_edge && w_in_active;
  // A trigger arriving in IDLE is served in the same cycle, so it wins a tie
  // against a CPU request that shows up together with it.
  assign w_disp_req    = r_disp_pend || w_trig;
  assign w_capture     = (r_state == S_WAIT) && r_is_disp;
  // First group of a line restarts the column count at zero.
  assign w_trig_addr     = BASE_ADDR + r_row_off + (w_first_group ? 16'd0 : r_col);
  assign w_disp_sel_addr = r_disp_pend ? r_disp_addr : w_trig_addr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state and slot selection
  always_comb begin
    w_state_next = r_state;
    w_sel_disp   = 1'b0;
    w_sel_cpu    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_disp_req) begin
          w_sel_disp   = 1'b1;
          w_state_next = S_ACCESS;
        end else if (cpu_req && !r_cpu_ack) begin
          w_sel_cpu    = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: w_state_next = S_WAIT;
      S_WAIT:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Row base steps by one tile row every 8 lines, rewinding at the frame top
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_off <= 16'd0;
    end else if (pix_en && (hcount == 10'd0)) begin
      if (vcount == 10'd0)            r_row_off <= 16'd0;
      else if (vcount[2:0] == 3'd0)   r_row_off <= r_row_off + ROW_STEP;
    end
  end

  // Column counter and queued display request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= 16'd0;
      r_disp_pend <= 1'b0;
      r_disp_addr <= 16'd0;
    end else begin
      if (w_trig) begin
        r_col       <= w_first_group ? 16'd1 : r_col + 16'd1;
        r_disp_addr <= w_trig_addr;
      end
      // Keep pending if a new trigger lands while an older one is served.
      if (w_trig && !(w_sel_disp && !r_disp_pend)) r_disp_pend <= 1'b1;
      else if (w_sel_disp)                         r_disp_pend <= 1'b0;
    end
  end

  // Memory port drive and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= 16'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 16'd0;
      r_is_disp   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 16'd0;
      r_next_word <= 16'd0;
    end else begin
      r_cpu_ack <= 1'b0;
      if (w_sel_disp) begin
        r_mem_addr <= w_disp_sel_addr;
        r_mem_we   <= 1'b0;
        r_is_disp  <= 1'b1;
      end else if (w_sel_cpu) begin
        r_mem_addr  <= cpu_addr;
        r_mem_we    <= cpu_we;
        r_mem_wdata <= cpu_wdata;
        r_is_disp   <= 1'b0;
      end else begin
        r_mem_we <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        if (r_is_disp) begin
          r_next_word <= mem_rdata;
        end else begin
          r_cpu_rdata <= mem_rdata;
          r_cpu_ack   <= 1'b1;
        end
      end
    end
  end

  // Tile word hand-off to the pixel generator and underrun detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tile_word  <= 16'd0;
      r_tile_valid <= 1'b0;
      r_underrun   <= 1'b0;
      r_next_ok    <= 1'b0;
    end else begin
      if (w_load) begin
        r_tile_word  <= r_next_word;
        r_tile_valid <= 1'b1;
        if (!r_next_ok) r_underrun <= 1'b1;
      end else if (pix_en && !w_in_active) begin
        r_tile_valid <= 1'b0;
      end
      if (w_capture)   r_next_ok <= 1'b1;
      else if (w_load) r_next_ok <= 1'b0;
    end
  end

  assign cpu_ack     = r_cpu_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign tile_word   = r_tile_word;
  assign tile_valid  = r_tile_valid;
  assign underrun    = r_underrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: VRAM model holding VRAM[i] = i until written,
// directed display lines, CPU accesses in blanking, tie and reset cases.
module tb_vga_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] tile_word;
  logic        tile_valid;
  logic        underrun;
  logic [1:0]  o_dbg_state;

  vga_vram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .tile_word  (tile_word),
    .tile_valid (tile_valid),
    .underrun   (underrun),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- VRAM model ----------------
  logic [15:0] vram    [0:65535];
  logic        vram_wr [0:65535];

  always @(posedge clk) begin
    if (rst === 1'b1 && $time < 100) begin
      for (int i = 0; i < 65536; i++) vram_wr[i] <= 1'b0;
    end
    mem_rdata <= vram_wr[mem_addr] ? vram[mem_addr] : mem_addr;
    if (mem_we) begin
      vram[mem_addr]    <= mem_wdata;
      vram_wr[mem_addr] <= 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic        mon_en;
  logic [15:0] obs_mem [0:1023];
  int          obs_n;
  int          we_cnt;
  int          ack_cnt;

  initial begin
    obs_n   = 0;
    we_cnt  = 0;
    ack_cnt = 0;
  end

  always @(negedge clk) begin
    if (mon_en && o_dbg_state == 2'd1) begin
      obs_mem[obs_n % 1024] = mem_addr;
      obs_n = obs_n + 1;
    end
    if (mem_we)  we_cnt  = we_cnt + 1;
    if (cpu_ack) ack_cnt = ack_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_pass;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pix(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Active lines: tile words at hcount 160/168 follow VRAM[i] = i.
  task automatic run_line(input int v, input int h0);
    for (int h = h0; h < 800; h++) begin
      pix(h, v);
      if (v < 480 && (h == 160 || h == 168)) begin
        chk("tile_word", 32'(tile_word), 32'((v / 8) * 80 + (h - 160) / 8));
        chk("tile_valid", 32'(tile_valid), 32'd1);
      end
    end
  endtask

  task automatic check_fetches(input int v, input int base);
    chk("fetch_count", 32'(obs_n - base), 32'd80);
    for (int g = 0; g < 80; g++) exp_q.push_back(16'((v / 8) * 80 + g));
    for (int g = 0; g < 80; g++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      chk("fetch_addr", 32'(obs_mem[(base + g) % 1024]), 32'(e));
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    lat = -1;
    rd  = 16'd0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        lat = k;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cpu_ack"},    32'(cpu_ack),     32'd0);
    chk({tag, "_cpu_rdata"},  32'(cpu_rdata),   32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),    32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),      32'd0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata),   32'd0);
    chk({tag, "_tile_word"},  32'(tile_word),   32'd0);
    chk({tag, "_tile_valid"}, 32'(tile_valid),  32'd0);
    chk({tag, "_underrun"},   32'(underrun),    32'd0);
    chk({tag, "_state"},      32'(o_dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          b;
    int          wb;
    int          ab;
    int          lat;
    logic [15:0] rd;

    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    pix_en    = 1'b0;
    hcount    = 10'd0;
    vcount    = 10'd0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'd0;
    cpu_wdata = 16'd0;
    mon_en    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Line 0: 80 reads at 0x0000..0x004F, no writes.
    mon_en = 1'b1;
    b  = obs_n;
    wb = we_cnt;
    run_line(0, 0);
    check_fetches(0, b);
    chk("line0_no_write", 32'(we_cnt - wb), 32'd0);

    // Line 8: row base 0x0050.
    for (int v = 1; v < 8; v++) pix(0, v);
    b = obs_n;
    run_line(8, 0);
    check_fetches(8, b);

    // Line 479: row base 59*80 = 0x1270.
    for (int v = 9; v < 479; v++) pix(0, v);
    b = obs_n;
    run_line(479, 0);
    check_fetches(479, b);

    // Line 480: no fetches, tile_valid low, tile_word holds the last group.
    b = obs_n;
    pix(0, 480);
    pix(152, 480);
    pix(160, 480);
    chk("v480_fetches", 32'(obs_n - b), 32'd0);
    chk("v480_tile_valid", 32'(tile_valid), 32'd0);
    chk("v480_tile_hold", 32'(tile_word), 32'h12BF);
    mon_en = 1'b0;

    // Blanking: CPU write 0xBEEF to 0x0100.
    pix(0, 500);
    wb        = we_cnt;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0100;
    cpu_wdata = 16'hBEEF;
    @(posedge clk); #1;
    chk("wr_access_we",    32'(mem_we),    32'd1);
    chk("wr_access_addr",  32'(mem_addr),  32'h0100);
    chk("wr_access_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("wr_access_ack",   32'(cpu_ack),   32'd0);
    @(posedge clk); #1;
    chk("wr_wait_we",  32'(mem_we),  32'd0);
    chk("wr_wait_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1;
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    chk("wr_we_cycles", 32'(we_cnt - wb), 32'd1);
    chk("wr_vram", 32'(vram[16'h0100]), 32'hBEEF);
    @(posedge clk); #1;

    // CPU read back.
    cpu_xfer(1'b0, 16'h0100, 16'h0000, lat, rd);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'hBEEF);
    @(posedge clk); #1;
    chk("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    chk("rd_data_held", 32'(cpu_rdata), 32'hBEEF);

    // Reset during a CPU write ACCESS cycle.
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0200;
    cpu_wdata = 16'h1234;
    @(posedge clk); #1;
    chk("rst_pre_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check_all_zero("rst_mid");
        rst = 1'b0;
      end
      if (cpu_ack) begin
        lat = k;
        break;
      end
    end
    chk("rst_rearb_latency", 32'(lat), 32'd4);
    chk("rst_rearb_addr", 32'(mem_addr), 32'h0200);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    @(posedge clk); #1;

    // Tie: CPU request in the same cycle as the display trigger at hcount 152.
    pix(0, 0);
    for (int h = 1; h < 152; h++) pix(h, 0);
    hcount   = 10'd152;
    vcount   = 10'd0;
    pix_en   = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0100;
    @(posedge clk); #1;
    pix_en = 1'b0;
    chk("tie_disp_addr",  32'(mem_addr),    32'h0000);
    chk("tie_disp_state", 32'(o_dbg_state), 32'd1);
    chk("tie_disp_we",    32'(mem_we),      32'd0);
    lat = -1;
    for (int k = 2; k <= 30; k++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        lat = k;
        break;
      end
    end
    chk("tie_cpu_latency", 32'(lat), 32'd6);
    chk("tie_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

    // cpu_req held high across active lines: display still keeps up.
    ab = ack_cnt;
    run_line(0, 153);
    for (int v = 1; v < 8; v++) pix(0, v);
    run_line(8, 0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (cpu_ack) break;
    end
    cpu_req = 1'b0;
    chk("cpu_served", 32'((ack_cnt - ab) >= 100), 32'd1);
    chk("no_underrun", 32'(underrun), 32'd0);
    @(posedge clk); #1;

    // Underrun: a group loaded without its fetch having been captured.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ur_after_rst", 32'(underrun), 32'd0);
    pix(0, 0);
    pix(160, 0);
    chk("ur_set", 32'(underrun), 32'd1);
    chk("ur_tile_valid", 32'(tile_valid), 32'd1);
    pix(0, 500);
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_blank_valid", 32'(tile_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
